hdlc_rx_framer: RTL and testbench

HDLC_RX_FRAMER -- requirements
Module: hdlc_rx_framer

---
 rtl/hdlc_rx_framer.sv | 219 +++++++++++++++++++++
 tb/tb_hdlc_rx_framer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_framer.sv
// HDLC receive framer: flag/abort detection, zero de-stuffing and a frame buffer read out byte by byte.
// Optional FCS residue check is built in when HDLC_RX_FCS_CHECK_EN is defined.
module hdlc_rx_framer #(
  parameter int MAX_BYTES = 128,
  parameter int FCS_BYTES = 2
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           Rx,
  input  logic                           RxEN,
  input  logic                           Rx_RdBuff,
  input  logic                           Rx_Drop,
  output logic [7:0]                     Rx_DataOut,
  output logic                           Rx_Ready,
  output logic [$clog2(MAX_BYTES+1)-1:0] Rx_FrameSize,
  output logic                           Rx_EoF,
  output logic                           Rx_AbortSignal,
  output logic                           Rx_FrameError,
  output logic                           Rx_FCSerr,
  output logic                           Rx_Overflow
);
  // state  | meaning
  // S_HUNT | searching the line for an opening flag
  // S_SYNC | flag seen, waiting for the first non-flag byte
  // S_DATA | de-stuffing and storing bytes until flag or abort
  // S_HOLD | good frame stored, Rx_Ready high, host reads or drops it
  localparam logic [1:0] S_HUNT = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int AW = $clog2(MAX_BYTES);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);
  localparam logic [CW-1:0] FCS_CNT = CW'(FCS_BYTES);

  logic [1:0]    r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_cnt8;
  logic [2:0]    r_ones;
  logic [2:0]    r_bitcnt;
  logic [6:0]    r_byte;
  logic [CW-1:0] r_bytecnt;
  logic [CW-1:0] r_rdptr;
  logic [CW-1:0] r_size;
  logic [7:0]    r_dout;
  logic          r_eof;
  logic          r_abort;
  logic          r_ferr;
  logic          r_fcserr;
  logic          r_ovf;
  logic [7:0]    r_mem [MAX_BYTES];

  logic [7:0]    w_shift_nxt;
  logic          w_flag;
  logic          w_abort;
  logic          w_bit;
  logic          w_stuffed;
  logic          w_take;
  logic [7:0]    w_byte;
  logic          w_byte_done;
  logic [2:0]    w_bitcnt_nxt;
  logic [2:0]    w_ones_nxt;
  logic [CW-1:0] w_bytecnt_nxt;
  logic          w_wr_en;
  logic [7:0]    w_rd_data;
  logic          w_fcs_bad;

  // Data bits are taken from the far end of the shift register, so the
  // closing flag's own bits never reach the byte assembler.
  assign w_shift_nxt   = {Rx, r_shift[7:1]};
  assign w_flag        = (w_shift_nxt == 8'h7E);
  assign w_abort       = &w_shift_nxt[7:1];
  assign w_bit         = r_shift[0];
  assign w_stuffed     = (r_ones == 3'd5) && !w_bit;
  assign w_take        = !w_stuffed;
  assign w_byte        = {w_bit, r_byte};
  assign w_byte_done   = w_take && (r_bitcnt == 3'd7);
  assign w_bitcnt_nxt  = w_take ? r_bitcnt + 3'd1 : r_bitcnt;
  assign w_ones_nxt    = (w_take && w_bit) ? r_ones + 3'd1 : 3'd0;
  assign w_bytecnt_nxt = (w_byte_done && (r_bytecnt != MAX_CNT)) ? r_bytecnt + 1'b1 : r_bytecnt;
  assign w_wr_en       = RxEN && (r_state == S_DATA) && !w_abort && w_byte_done && (r_bytecnt != MAX_CNT);
  assign w_rd_data     = r_mem[r_rdptr[AW-1:0]];

`ifdef HDLC_RX_FCS_CHECK_EN
  logic [15:0] r_crc;
  logic [15:0] w_crc_nxt;

  assign w_crc_nxt = (r_crc[0] ^ w_bit) ? ({1'b0, r_crc[15:1]} ^ 16'h8408) : {1'b0, r_crc[15:1]};
  assign w_fcs_bad = ((w_take ? w_crc_nxt : r_crc) != 16'hF0B8);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_crc <= 16'hFFFF;
    end else if (RxEN) begin
      if (r_state == S_SYNC) begin
        r_crc <= 16'hFFFF;
      end else if ((r_state == S_DATA) && w_take) begin
        r_crc <= w_crc_nxt;
      end
    end
  end
`else
  assign w_fcs_bad = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (w_wr_en) begin
      r_mem[r_bytecnt[AW-1:0]] <= w_byte;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= S_HUNT;
      r_shift   <= 8'h00;
      r_cnt8    <= 3'd0;
      r_ones    <= 3'd0;
      r_bitcnt  <= 3'd0;
      r_byte    <= 7'd0;
      r_bytecnt <= '0;
      r_rdptr   <= '0;
      r_size    <= '0;
      r_dout    <= 8'h00;
      r_eof     <= 1'b0;
      r_abort   <= 1'b0;
      r_ferr    <= 1'b0;
      r_fcserr  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_eof   <= 1'b0;
      r_abort <= 1'b0;
      r_ferr  <= 1'b0;
      if (RxEN) begin
        r_shift <= w_shift_nxt;
      end
      case (r_state)
        S_HUNT: begin
          if (RxEN && w_flag) begin
            r_state <= S_SYNC;
            r_cnt8  <= 3'd0;
            r_ovf   <= 1'b0;
          end
        end
        S_SYNC: begin
          if (RxEN) begin
            if (w_flag) begin
              r_cnt8 <= 3'd0;
            end else if (w_abort) begin
              r_state <= S_HUNT;
            end else if (r_cnt8 == 3'd7) begin
              r_state   <= S_DATA;
              r_ones    <= 3'd0;
              r_bitcnt  <= 3'd0;
              r_bytecnt <= '0;
            end else begin
              r_cnt8 <= r_cnt8 + 3'd1;
            end
          end
        end
        S_DATA: begin
          if (RxEN) begin
            if (w_abort) begin
              r_abort <= 1'b1;
              r_state <= S_HUNT;
            end else begin
              r_ones    <= w_ones_nxt;
              r_bitcnt  <= w_bitcnt_nxt;
              r_bytecnt <= w_bytecnt_nxt;
              if (w_take) begin
                r_byte <= w_byte[7:1];
              end
              if (w_byte_done && (r_bytecnt == MAX_CNT)) begin
                r_ovf <= 1'b1;
              end
              // The bit leaving the shift register on the flag cycle is the frame's last bit.
              if (w_flag) begin
                if ((w_bitcnt_nxt != 3'd0) || (w_bytecnt_nxt <= FCS_CNT)) begin
                  r_ferr  <= 1'b1;
                  r_state <= S_HUNT;
                end else begin
                  r_state  <= S_HOLD;
                  r_eof    <= 1'b1;
                  r_size   <= w_bytecnt_nxt - FCS_CNT;
                  r_rdptr  <= '0;
                  r_fcserr <= w_fcs_bad;
                end
              end
            end
          end
        end
        S_HOLD: begin
          if (Rx_Drop) begin
            r_state  <= S_HUNT;
            r_fcserr <= 1'b0;
          end else if (Rx_RdBuff) begin
            r_dout  <= w_rd_data;
            r_rdptr <= r_rdptr + 1'b1;
            if (r_rdptr == r_size - 1'b1) begin
              r_state  <= S_HUNT;
              r_fcserr <= 1'b0;
            end
          end
        end
        default: r_state <= S_HUNT;
      endcase
    end
  end

  assign Rx_DataOut     = r_dout;
  assign Rx_Ready       = (r_state == S_HOLD);
  assign Rx_FrameSize   = r_size;
  assign Rx_EoF         = r_eof;
  assign Rx_AbortSignal = r_abort;
  assign Rx_FrameError  = r_ferr;
  assign Rx_FCSerr      = r_fcserr;
  assign Rx_Overflow    = r_ovf;

endmodule

// File: tb/tb_hdlc_rx_framer.sv
// Bench for hdlc_rx_framer: two instances (deep and 4-byte buffer) share one serial line and host strobes.
// Frames are built as byte lists, FCS-appended and zero-stuffed here; expectations come from the byte list.
`timescale 1ns/1ps
module tb_hdlc_rx_framer;
  localparam int FCS   = 2;
  localparam int MAX_B = 128;
  localparam int MAX_S = 4;
  localparam int CWB   = $clog2(MAX_B + 1);
  localparam int CWS   = $clog2(MAX_S + 1);

  logic Clk = 1'b0;
  logic Rst, Rx, RxEN, Rx_RdBuff, Rx_Drop;
  logic [7:0] b_dout, s_dout;
  logic [CWB-1:0] b_size;
  logic [CWS-1:0] s_size;
  logic b_ready, s_ready, b_eof, s_eof, b_abort, s_abort;
  logic b_ferr, s_ferr, b_fcserr, s_fcserr, b_ovf, s_ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [7:0] frm[$];
  logic [7:0] exp_b_dout, exp_s_dout;
  logic exp_fcserr;

  always #5 Clk = ~Clk;

  hdlc_rx_framer #(.MAX_BYTES(MAX_B), .FCS_BYTES(FCS)) u_big (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .RxEN(RxEN), .Rx_RdBuff(Rx_RdBuff), .Rx_Drop(Rx_Drop),
    .Rx_DataOut(b_dout), .Rx_Ready(b_ready), .Rx_FrameSize(b_size), .Rx_EoF(b_eof),
    .Rx_AbortSignal(b_abort), .Rx_FrameError(b_ferr), .Rx_FCSerr(b_fcserr), .Rx_Overflow(b_ovf));

  hdlc_rx_framer #(.MAX_BYTES(MAX_S), .FCS_BYTES(FCS)) u_small (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .RxEN(RxEN), .Rx_RdBuff(Rx_RdBuff), .Rx_Drop(Rx_Drop),
    .Rx_DataOut(s_dout), .Rx_Ready(s_ready), .Rx_FrameSize(s_size), .Rx_EoF(s_eof),
    .Rx_AbortSignal(s_abort), .Rx_FrameError(s_ferr), .Rx_FCSerr(s_fcserr), .Rx_Overflow(s_ovf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reflected CRC-16-CCITT over the first n bytes of frm.
  function automatic logic [15:0] crc_of(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++)
        c = (c[0] ^ frm[i][k]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return c;
  endfunction

  task automatic add_fcs(input bit corrupt);
    logic [15:0] f;
    f = ~crc_of(frm.size());
    if (corrupt) f[3] = ~f[3];
    frm.push_back(f[7:0]);
    frm.push_back(f[15:8]);
`ifdef HDLC_RX_FCS_CHECK_EN
    exp_fcserr = corrupt;
`else
    exp_fcserr = 1'b0;
`endif
  endtask

  task automatic send_bit(input logic b);
    if ($urandom_range(0, 5) == 0) begin
      RxEN = 1'b0;
      Rx   = 1'($urandom);
      @(posedge Clk); #1;
    end
    RxEN = 1'b1;
    Rx   = b;
    @(posedge Clk); #1;
    Rx = 1'b1;
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int k = 0; k < 8; k++) send_bit(f[k]);
  endtask

  // First nb logical bits of frm, LSB first, with a zero inserted after every five ones.
  task automatic send_payload(input int nb);
    int ones;
    logic b;
    ones = 0;
    for (int i = 0; i < nb; i++) begin
      b = frm[i / 8][i % 8];
      send_bit(b);
      ones = b ? ones + 1 : 0;
      if (ones == 5) begin
        send_bit(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic run_frame(input int nb, input bit abort_end);
    for (int i = 0; i < 2 + $urandom_range(0, 3); i++) send_bit(1'b1);
    if ($urandom_range(0, 1) == 1) send_flag();
    send_flag();
    send_payload(nb);
    if (abort_end) begin
      for (int i = 0; i < 7; i++) send_bit(1'b1);
    end else begin
      send_flag();
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_dout_b"}, b_dout, 0);   chk({tag, "_dout_s"}, s_dout, 0);
    chk({tag, "_rdy_b"}, b_ready, 0);   chk({tag, "_rdy_s"}, s_ready, 0);
    chk({tag, "_size_b"}, b_size, 0);   chk({tag, "_size_s"}, s_size, 0);
    chk({tag, "_eof_b"}, b_eof, 0);     chk({tag, "_eof_s"}, s_eof, 0);
    chk({tag, "_abt_b"}, b_abort, 0);   chk({tag, "_abt_s"}, s_abort, 0);
    chk({tag, "_ferr_b"}, b_ferr, 0);   chk({tag, "_ferr_s"}, s_ferr, 0);
    chk({tag, "_fcs_b"}, b_fcserr, 0);  chk({tag, "_fcs_s"}, s_fcserr, 0);
    chk({tag, "_ovf_b"}, b_ovf, 0);     chk({tag, "_ovf_s"}, s_ovf, 0);
    exp_b_dout = 8'h00;
    exp_s_dout = 8'h00;
  endtask

  task automatic expect_stored(input bit drop);
    int nby, szb, szs, nr;
    nby = frm.size();
    szb = ((nby > MAX_B) ? MAX_B : nby) - FCS;
    szs = ((nby > MAX_S) ? MAX_S : nby) - FCS;
    chk("rdy_b", b_ready, 1);          chk("rdy_s", s_ready, 1);
    chk("eof_b", b_eof, 1);            chk("eof_s", s_eof, 1);
    chk("size_b", b_size, szb);        chk("size_s", s_size, szs);
    chk("ovf_b", b_ovf, nby > MAX_B);  chk("ovf_s", s_ovf, nby > MAX_S);
    chk("fcserr_b", b_fcserr, exp_fcserr);
    chk("fcserr_s", s_fcserr, exp_fcserr);
    chk("ferr_b", b_ferr, 0);          chk("ferr_s", s_ferr, 0);
    @(posedge Clk); #1;
    chk("eof_pulse_b", b_eof, 0);      chk("eof_pulse_s", s_eof, 0);
    if (drop) begin
      Rx_Drop   = 1'b1;
      Rx_RdBuff = 1'b1;
      @(posedge Clk); #1;
      Rx_Drop   = 1'b0;
      Rx_RdBuff = 1'b0;
      chk("drop_rdy_b", b_ready, 0);   chk("drop_rdy_s", s_ready, 0);
      chk("drop_dout_b", b_dout, exp_b_dout);
      chk("drop_dout_s", s_dout, exp_s_dout);
    end else begin
      nr = (szb > szs) ? szb : szs;
      Rx_RdBuff = 1'b1;
      for (int i = 0; i < nr; i++) begin
        @(posedge Clk); #1;
        if (i < szb) exp_b_dout = frm[i];
        if (i < szs) exp_s_dout = frm[i];
        chk("rd_b", b_dout, exp_b_dout);
        chk("rd_s", s_dout, exp_s_dout);
        chk("rd_rdy_b", b_ready, i < szb - 1);
        chk("rd_rdy_s", s_ready, i < szs - 1);
      end
      Rx_RdBuff = 1'b0;
    end
    // A read strobe outside HOLD must leave the output alone.
    Rx_RdBuff = 1'b1;
    @(posedge Clk); #1;
    Rx_RdBuff = 1'b0;
    chk("stray_rd_b", b_dout, exp_b_dout);
    chk("stray_rd_s", s_dout, exp_s_dout);
  endtask

  task automatic expect_ferr();
    chk("ferr_b", b_ferr, 1);        chk("ferr_s", s_ferr, 1);
    chk("ferr_rdy_b", b_ready, 0);   chk("ferr_rdy_s", s_ready, 0);
    @(posedge Clk); #1;
    chk("ferr_pulse_b", b_ferr, 0);  chk("ferr_pulse_s", s_ferr, 0);
    chk("ferr_rdy2_b", b_ready, 0);  chk("ferr_rdy2_s", s_ready, 0);
  endtask

  task automatic expect_abort();
    chk("abt_b", b_abort, 1);        chk("abt_s", s_abort, 1);
    chk("abt_rdy_b", b_ready, 0);    chk("abt_rdy_s", s_ready, 0);
    @(posedge Clk); #1;
    chk("abt_pulse_b", b_abort, 0);  chk("abt_pulse_s", s_abort, 0);
  endtask

  task automatic rand_payload(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
  endtask

  initial begin
    Rst = 1'b1; Rx = 1'b1; RxEN = 1'b0; Rx_RdBuff = 1'b0; Rx_Drop = 1'b0;
    exp_fcserr = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    check_reset("por");

    frm.delete(); frm.push_back(8'hA5); frm.push_back(8'h3C);
    add_fcs(1'b0);
    run_frame(8 * frm.size(), 1'b0);
    expect_stored(1'b0);

    frm.delete(); frm.push_back(8'hFF);
    add_fcs(1'b0);
    run_frame(8 * frm.size(), 1'b0);
    expect_stored(1'b0);

    rand_payload(2);
    run_frame(12, 1'b0);
    expect_ferr();

    frm.delete(); add_fcs(1'b0);
    run_frame(8 * frm.size(), 1'b0);
    expect_ferr();

    frm.delete(); frm.push_back(8'($urandom) & 8'h7F);
    run_frame(8, 1'b1);
    expect_abort();
    rand_payload(3); add_fcs(1'b0);
    run_frame(8 * frm.size(), 1'b0);
    expect_stored(1'b0);

    rand_payload(6); add_fcs(1'b1);
    run_frame(8 * frm.size(), 1'b0);
    expect_stored(1'b0);

    rand_payload(3); add_fcs(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    send_flag();
    send_payload(20);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    check_reset("mid");
    rand_payload(2); add_fcs(1'b0);
    run_frame(8 * frm.size(), 1'b0);
    expect_stored(1'b0);

    for (int f = 0; f < 6; f++) begin
      rand_payload($urandom_range(1, 8));
      add_fcs(1'($urandom_range(0, 1)));
      run_frame(8 * frm.size(), 1'b0);
      expect_stored($urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
